npc_pipe: RTL and testbench

Registered next-PC unit for the pipelined CPU: holds the fetch PC, advances it sequentially, and applies branch, jump, jump-register and exception redirects resolved in EX. Redirects that arrive during a stall are buffered until the pipeline can move. It also drives the flush pulse for the IF/ID registers. An optional direct-mapped branch target buffer (BTB) predicts taken branches and jumps at fetch.

---
 rtl/npc_pipe.sv | 187 ++++++++++++++++++
 tb/tb_npc_pipe.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/npc_pipe.sv
// npc_pipe: registered fetch PC with EX-resolved redirects and stall buffering.
// Optional direct-mapped BTB is enabled by defining NPC_BTB_EN.
module npc_pipe #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_0180,
    parameter int          BTB_IDX_W = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              stall_i,
    input  logic              ex_valid_i,
    input  logic [2:0]        ex_op_i,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic [25:0]       ex_imm_i,
    input  logic [ADDR_W-1:0] ex_rs_i,
    input  logic              ex_pred_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pcplus4_o,
    output logic              pred_o,
    output logic              redirect_o
);

    localparam logic [2:0] OP_PLUS4  = 3'b000;
    localparam logic [2:0] OP_BRANCH = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_JR     = 3'b011;
    localparam logic [2:0] OP_EXC    = 3'b100;

    localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] EXC_PC = EXC_VEC[ADDR_W-1:0];

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_v_q, pend_v_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;

    logic [ADDR_W-1:0] p4;
    logic [ADDR_W-1:0] br_tgt;
    logic [31:0]       p4_w;
    logic [31:0]       jmp_w;
    logic [ADDR_W-1:0] jmp_tgt;
    logic [ADDR_W-1:0] jr_tgt;

    logic              pred_eff;
    logic              redir;
    logic              is_exc;
    logic [ADDR_W-1:0] tgt;

    logic              btb_hit;
    logic [ADDR_W-1:0] btb_tgt;
    logic [ADDR_W-1:0] seq_next;

    assign p4      = ex_pc_i + ADDR_W'(4);
    assign br_tgt  = p4 + {{(ADDR_W-18){ex_imm_i[15]}}, ex_imm_i[15:0], 2'b00};
    assign p4_w    = 32'(p4);
    assign jmp_w   = {p4_w[31:28], ex_imm_i, 2'b00};
    assign jmp_tgt = jmp_w[ADDR_W-1:0];
    assign jr_tgt  = {ex_rs_i[ADDR_W-1:2], 2'b00};

`ifdef NPC_BTB_EN
    localparam int NE    = 1 << BTB_IDX_W;
    localparam int TAG_W = ADDR_W - BTB_IDX_W - 2;

    logic [NE-1:0]       val_q;
    logic [TAG_W-1:0]    tag_q [NE];
    logic [ADDR_W-1:0]   bt_q  [NE];
    logic [BTB_IDX_W-1:0] rd_idx;
    logic [BTB_IDX_W-1:0] wr_idx;
    logic                btb_wr;
    logic                btb_clr;

    assign pred_eff = ex_pred_i;
    assign rd_idx   = pc_q[BTB_IDX_W+1:2];
    assign wr_idx   = ex_pc_i[BTB_IDX_W+1:2];
    assign btb_wr   = ex_valid_i &&
                      (ex_op_i == OP_BRANCH || ex_op_i == OP_JUMP);
    assign btb_clr  = ex_valid_i && ex_op_i == OP_PLUS4 && ex_pred_i;
    assign btb_hit  = val_q[rd_idx] &&
                      (tag_q[rd_idx] == pc_q[ADDR_W-1:BTB_IDX_W+2]);
    assign btb_tgt  = bt_q[rd_idx];

    // BTB valid bits: set on taken branch/jump, cleared on mispredict
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            val_q <= '0;
        end else if (btb_wr) begin
            val_q[wr_idx] <= 1'b1;
        end else if (btb_clr) begin
            val_q[wr_idx] <= 1'b0;
        end
    end

    // BTB tag/target payload; only meaningful where valid is set
    always_ff @(posedge clk) begin
        if (btb_wr) begin
            tag_q[wr_idx] <= ex_pc_i[ADDR_W-1:BTB_IDX_W+2];
            bt_q[wr_idx]  <= tgt;
        end
    end
`else
    logic unused_pred;

    assign unused_pred = ex_pred_i;
    assign pred_eff    = 1'b0;
    assign btb_hit     = 1'b0;
    assign btb_tgt     = '0;
`endif

    // Decode EX control-flow op into redirect request and target
    always_comb begin
        redir  = 1'b0;
        is_exc = 1'b0;
        tgt    = p4;
        if (ex_valid_i) begin
            case (ex_op_i)
                OP_BRANCH: begin
                    tgt   = br_tgt;
                    redir = !pred_eff;
                end
                OP_JUMP: begin
                    tgt   = jmp_tgt;
                    redir = !pred_eff;
                end
                OP_JR: begin
                    tgt   = jr_tgt;
                    redir = 1'b1;
                end
                OP_EXC: begin
                    tgt    = EXC_PC;
                    redir  = 1'b1;
                    is_exc = 1'b1;
                end
                default: begin
                    tgt   = p4;
                    redir = pred_eff;
                end
            endcase
        end
    end

    assign seq_next = btb_hit ? btb_tgt : pc_q + ADDR_W'(4);

    // Next fetch PC: exception, redirect/buffer, pending replay, sequential
    always_comb begin
        pc_d      = pc_q;
        pend_v_d  = pend_v_q;
        pend_pc_d = pend_pc_q;
        if (is_exc) begin
            pc_d     = tgt;
            pend_v_d = 1'b0;
        end else if (redir) begin
            if (stall_i) begin
                pend_v_d  = 1'b1;
                pend_pc_d = tgt;
            end else begin
                pc_d     = tgt;
                pend_v_d = 1'b0;
            end
        end else if (!stall_i) begin
            if (pend_v_q) begin
                pc_d     = pend_pc_q;
                pend_v_d = 1'b0;
            end else begin
                pc_d = seq_next;
            end
        end
    end

    // PC and pending-redirect registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q      <= RST_PC;
            pend_v_q  <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            pend_v_q  <= pend_v_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign pc_o       = pc_q;
    assign pcplus4_o  = pc_q + ADDR_W'(4);
    assign pred_o     = btb_hit;
    assign redirect_o = redir & rstn;

endmodule

// File: tb/tb_npc_pipe.sv
// tb_npc_pipe: table-driven directed checks for npc_pipe.
// Expectations adapt to NPC_BTB_EN when it is defined.
module tb_npc_pipe;

    logic        clk;
    logic        rstn;
    logic        stall_i;
    logic        ex_valid_i;
    logic [2:0]  ex_op_i;
    logic [31:0] ex_pc_i;
    logic [25:0] ex_imm_i;
    logic [31:0] ex_rs_i;
    logic        ex_pred_i;
    logic [31:0] pc_o;
    logic [31:0] pcplus4_o;
    logic        pred_o;
    logic        redirect_o;

    int checks = 0;
    int errors = 0;

`ifdef NPC_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    npc_pipe #(
        .ADDR_W    (32),
        .RESET_PC  (32'h0000_3000),
        .EXC_VEC   (32'h0000_0180),
        .BTB_IDX_W (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .stall_i    (stall_i),
        .ex_valid_i (ex_valid_i),
        .ex_op_i    (ex_op_i),
        .ex_pc_i    (ex_pc_i),
        .ex_imm_i   (ex_imm_i),
        .ex_rs_i    (ex_rs_i),
        .ex_pred_i  (ex_pred_i),
        .pc_o       (pc_o),
        .pcplus4_o  (pcplus4_o),
        .pred_o     (pred_o),
        .redirect_o (redirect_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        vld;
        logic [2:0]  op;
        logic [31:0] pc;
        logic [25:0] imm;
        logic [31:0] rs;
        logic        pred;
        logic        e_red;
        logic        e_predo;
        logic [31:0] e_pc;
        logic        e_pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic st, input logic v, input logic [2:0] op,
        input logic [31:0] pc, input logic [25:0] imm,
        input logic [31:0] rs, input logic pr,
        input logic er, input logic ep, input logic [31:0] epc,
        input logic epend);
        vec_t r;
        r.stall = st; r.vld = v; r.op = op; r.pc = pc;
        r.imm = imm; r.rs = rs; r.pred = pr;
        r.e_red = er; r.e_predo = ep; r.e_pc = epc; r.e_pend = epend;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic v, input logic [2:0] op,
                         input logic [31:0] pc, input logic [25:0] imm,
                         input logic [31:0] rs, input logic pr);
        stall_i = st; ex_valid_i = v; ex_op_i = op; ex_pc_i = pc;
        ex_imm_i = imm; ex_rs_i = rs; ex_pred_i = pr;
    endtask

    initial begin
        // idle, BRANCH, JUMP, JR, EXC, plus4 encodings
        tbl.push_back(mk(0,0,3'd0,0,0,0,0, 0,0,32'h3004,0));
        tbl.push_back(mk(0,0,3'd0,0,0,0,0, 0,0,32'h3008,0));
        tbl.push_back(mk(0,0,3'd0,0,0,0,0, 0,0,32'h300C,0));
        tbl.push_back(mk(0,1,3'd1,32'h3004,26'h000FFFE,0,0,
                         1,0,32'h3000,0));
        tbl.push_back(mk(0,1,3'd2,32'h1000_0000,26'h0000040,0,0,
                         1,0,32'h1000_0100,0));
        tbl.push_back(mk(1,1,3'd3,0,0,32'h0000_4003,0,
                         1,0,32'h1000_0100,1));
        tbl.push_back(mk(1,0,3'd0,0,0,0,0, 0,0,32'h1000_0100,1));
        tbl.push_back(mk(1,0,3'd0,0,0,0,0, 0,0,32'h1000_0100,1));
        tbl.push_back(mk(0,0,3'd0,0,0,0,0, 0,0,32'h4000,0));
        tbl.push_back(mk(0,0,3'd0,0,0,0,0, 0,0,32'h4004,0));
        tbl.push_back(mk(1,1,3'd3,0,0,32'h5000,0, 1,0,32'h4004,1));
        tbl.push_back(mk(1,1,3'd4,32'h4000,0,0,0, 1,0,32'h0180,0));
        tbl.push_back(mk(0,0,3'd0,0,0,0,0, 0,0,32'h0184,0));
        tbl.push_back(mk(1,1,3'd3,0,0,32'h6000,0, 1,0,32'h0184,1));
        tbl.push_back(mk(1,1,3'd1,32'h0100,26'h0000004,0,0,
                         1,0,32'h0184,1));
        tbl.push_back(mk(0,0,3'd0,0,0,0,0, 0,0,32'h0114,0));
        tbl.push_back(mk(0,0,3'd3,0,0,32'h9000,0, 0,0,32'h0118,0));
        tbl.push_back(mk(0,1,3'd5,32'h0200,0,0,0, 0,0,32'h011C,0));
        tbl.push_back(mk(0,1,3'd0,32'h0200,0,0,1,
                         BTB,0,BTB ? 32'h0204 : 32'h0120,0));
        tbl.push_back(mk(0,1,3'd3,0,0,32'hFFFF_FFFF,0,
                         1,0,32'hFFFF_FFFC,0));
        tbl.push_back(mk(0,0,3'd0,0,0,0,0, 0,0,32'h0000_0000,0));
        tbl.push_back(mk(0,1,3'd1,32'hFFFF_FFF8,26'h0000001,0,0,
                         1,0,32'h0000_0000,0));
        // BTB train / predict / mispredict
        tbl.push_back(mk(0,1,3'd1,32'h3010,26'h000000B,0,0,
                         1,0,32'h3040,0));
        tbl.push_back(mk(0,1,3'd3,0,0,32'h3010,0, 1,0,32'h3010,0));
        tbl.push_back(mk(0,0,3'd0,0,0,0,0,
                         0,BTB,BTB ? 32'h3040 : 32'h3014,0));
        tbl.push_back(mk(0,1,3'd0,32'h3010,0,0,1,
                         BTB,0,BTB ? 32'h3014 : 32'h3018,0));
        tbl.push_back(mk(0,1,3'd3,0,0,32'h3010,0, 1,0,32'h3010,0));
        tbl.push_back(mk(0,1,3'd1,32'h3010,26'h000000B,0,1,
                         !BTB,0,BTB ? 32'h3014 : 32'h3040,0));
        tbl.push_back(mk(0,1,3'd3,0,0,32'h3010,0, 1,0,32'h3010,0));
        tbl.push_back(mk(0,0,3'd0,0,0,0,0,
                         0,BTB,BTB ? 32'h3040 : 32'h3014,0));

        // reset state, with an EXC presented to check redirect_o gating
        rstn = 1'b0;
        drive(0,1,3'd4,32'h0,26'h0,32'h0,0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", pc_o, 32'h3000);
        chk("rst_pcplus4", pcplus4_o, 32'h3004);
        chk("rst_redirect", {31'b0, redirect_o}, 32'd0);
        chk("rst_pred", {31'b0, pred_o}, 32'd0);
        chk("rst_pend", {31'b0, dut.pend_v_q}, 32'd0);
        rstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stall, tbl[i].vld, tbl[i].op, tbl[i].pc,
                  tbl[i].imm, tbl[i].rs, tbl[i].pred);
            #1;
            chk($sformatf("v%0d_redirect", i),
                {31'b0, redirect_o}, {31'b0, tbl[i].e_red});
            chk($sformatf("v%0d_pred", i),
                {31'b0, pred_o}, {31'b0, tbl[i].e_predo});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc", i), pc_o, tbl[i].e_pc);
            chk($sformatf("v%0d_pcplus4", i), pcplus4_o,
                tbl[i].e_pc + 32'd4);
            chk($sformatf("v%0d_pend", i),
                {31'b0, dut.pend_v_q}, {31'b0, tbl[i].e_pend});
            @(negedge clk);
        end

        // reset asserted mid-stall with a pending redirect
        drive(1,1,3'd3,32'h0,26'h0,32'h0000_7000,0);
        @(posedge clk);
        #1;
        chk("mid_pend_set", {31'b0, dut.pend_v_q}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_pc", pc_o, 32'h3000);
        chk("mid_rst_redirect", {31'b0, redirect_o}, 32'd0);
        chk("mid_rst_pend", {31'b0, dut.pend_v_q}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        drive(1,0,3'd0,32'h0,26'h0,32'h0,0);
        @(posedge clk);
        #1;
        chk("mid_stall_hold", pc_o, 32'h3000);
        @(negedge clk);
        stall_i = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_resume", pc_o, 32'h3004);
        chk("mid_resume_pend", {31'b0, dut.pend_v_q}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
